// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer
//   Queues byte-masked stores and sequences them into a single-port data
//   memory. Loads normally win the port. A store is forced through when the
//   load address hits a queued entry, after STARVE_MAX consecutive lost
//   arbitrations, or while a fence drain is in progress.
// Ports
//   clk_i, rst_n_i                     clock / async active-low reset
//   st_valid_i/st_ready_o              store handshake
//   st_addr_i/st_mask_i/st_data_i      store word address, byte mask, data
//   ld_valid_i/ld_addr_i/ld_grant_o    load request and combinational grant
//   fence_i/busy_o                     fence pulse / drain in progress
//   mem_en_o/mem_we_o/mem_addr_o/mem_din_o  memory port
module dmem_store_buffer #(
    parameter int WIDTH      = 32,
    parameter int ADDR_W     = 14,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [ADDR_W-1:0] st_addr_i,
    input  logic [3:0]        st_mask_i,
    input  logic [WIDTH-1:0]  st_data_i,
    input  logic              ld_valid_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    output logic              ld_grant_o,
    input  logic              fence_i,
    output logic              busy_o,
    output logic              mem_en_o,
    output logic [3:0]        mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_din_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX    = SW'(STARVE_MAX);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [3:0]        mask_q [DEPTH];
    logic [WIDTH-1:0]  data_q [DEPTH];

    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, rptr_q;
    logic [SW-1:0] starve_q, starve_d;
    logic [0:0]    state_q, state_d;

    logic [DEPTH-1:0] ent_vld;
    logic [PW-1:0]    off;
    logic             hazard, drain, grant, enq;

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        ent_vld = '0;
        off     = '0;
        hazard  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = PW'(i) - rptr_q;
            ent_vld[i] = {1'b0, off} < count_q;
            if (ent_vld[i] && addr_q[i] == ld_addr_i)
                hazard = ld_valid_i;
        end
    end

    // Port arbitration. A hazard implies a non-empty buffer, so every forced
    // drain reason lives under count!=0.
    always_comb begin
        drain = 1'b0;
        grant = 1'b0;
        if (count_q != '0) begin
            if (hazard || state_q == ST_DRAIN || starve_q == SMAX)
                drain = 1'b1;
            else if (ld_valid_i)
                grant = 1'b1;
            else
                drain = 1'b1;
        end else if (ld_valid_i) begin
            grant = 1'b1;
        end
    end

    // Ready looks at the registered count only: no pass-through into a full buffer.
    assign st_ready_o = (count_q < DEPTH_C) && (state_q == ST_IDLE);
    assign enq        = st_valid_i && st_ready_o && (st_mask_i != 4'b0000);
    assign count_d    = count_q + CW'(enq) - CW'(drain);

    always_comb begin
        starve_d = starve_q;
        if (drain || count_q == '0)
            starve_d = '0;
        else if (grant && starve_q != SMAX)
            starve_d = starve_q + SW'(1);
    end

    // Enter DRAIN only if something is still queued after this cycle;
    // otherwise a fence racing the last pop would leave the FSM stuck busy.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (fence_i && count_q != '0 && count_d != '0)
                state_d = ST_DRAIN;
        end else if (count_d == '0) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q  <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            starve_q <= '0;
            state_q  <= ST_IDLE;
        end else begin
            count_q  <= count_d;
            starve_q <= starve_d;
            state_q  <= state_d;
            if (enq)   wptr_q <= wptr_q + PW'(1);
            if (drain) rptr_q <= rptr_q + PW'(1);
        end
    end

    // Payload storage needs no reset; liveness is tracked by count/pointers.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            addr_q[wptr_q] <= st_addr_i;
            mask_q[wptr_q] <= st_mask_i;
            data_q[wptr_q] <= st_data_i;
        end
    end

    // Port strobes are qualified by reset so a load held high during reset
    // cannot reach the memory.
    assign ld_grant_o = rst_n_i && grant;
    assign mem_en_o   = rst_n_i && (drain || grant);
    assign mem_we_o   = (rst_n_i && drain) ? mask_q[rptr_q] : 4'b0000;
    assign mem_addr_o = drain ? addr_q[rptr_q] : ld_addr_i;
    assign mem_din_o  = data_q[rptr_q];
    assign busy_o     = (state_q == ST_DRAIN);
endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;
    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        st_valid = 1'b0, ld_valid = 1'b0, fence = 1'b0;
    logic [13:0] st_addr = '0, ld_addr = '0;
    logic [3:0]  st_mask = '0;
    logic [31:0] st_data = '0;
    logic        st_ready, ld_grant, busy, mem_en;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_din;

    int tests = 0, fails = 0, wr_bad = 0;
    bit chk_en = 1'b0;

    dmem_store_buffer #(.WIDTH(32), .ADDR_W(14), .DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .st_valid_i(st_valid), .st_ready_o(st_ready),
        .st_addr_i(st_addr), .st_mask_i(st_mask), .st_data_i(st_data),
        .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_grant_o(ld_grant),
        .fence_i(fence), .busy_o(busy),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_din_o(mem_din)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
        end
    endtask

    // Behavioural model: a queue of pending stores plus a starvation count
    // and a drain flag.
    typedef struct { logic [13:0] a; logic [3:0] m; logic [31:0] d; } ent_t;
    ent_t q[$];
    int   starve = 0;
    bit   mdrain = 1'b0;
    bit   d_drain, d_grant, d_enq, d_fence;
    int   d_n;
    ent_t d_new;

    always @(negedge clk) begin
        if (chk_en) begin
            int  n;
            bit  hz, e_ready;
            n  = q.size();
            hz = 1'b0;
            foreach (q[i]) if (ld_valid && q[i].a == ld_addr) hz = 1'b1;
            d_drain = 1'b0;
            d_grant = 1'b0;
            if (rst_n) begin
                if (hz)                         d_drain = 1'b1;
                else if (mdrain && n > 0)       d_drain = 1'b1;
                else if (starve == SMAX && n > 0) d_drain = 1'b1;
                else if (ld_valid)              d_grant = 1'b1;
                else if (n > 0)                 d_drain = 1'b1;
            end
            e_ready = (n < DEPTH) && !mdrain;
            chk("st_ready", st_ready, e_ready);
            chk("busy", busy, mdrain);
            chk("ld_grant", ld_grant, d_grant);
            chk("mem_en", mem_en, d_drain | d_grant);
            chk("mem_we", mem_we, d_drain ? q[0].m : 4'b0000);
            if (d_drain) begin
                chk("mem_addr_st", mem_addr, q[0].a);
                chk("mem_din", mem_din, q[0].d);
            end else if (d_grant) begin
                chk("mem_addr_ld", mem_addr, ld_addr);
            end
            d_enq   = rst_n && st_valid && e_ready && (st_mask != 4'b0000);
            d_fence = fence;
            d_n     = n;
            d_new   = '{a: st_addr, m: st_mask, d: st_data};
            if (rst_n && mem_we != 4'b0000 && (mem_addr == 14'h0E0 || mem_addr == 14'h0F0))
                wr_bad++;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            starve = 0;
            mdrain = 1'b0;
        end else begin
            if (d_drain) void'(q.pop_front());
            if (d_enq)   q.push_back(d_new);
            if (d_drain || d_n == 0)              starve = 0;
            else if (d_grant && starve < SMAX)    starve++;
            // Fence starts a drain only if stores remain after this edge.
            if (!mdrain && d_fence && d_n > 0 && q.size() > 0) mdrain = 1'b1;
            else if (mdrain && q.size() == 0)                  mdrain = 1'b0;
        end
        d_drain = 1'b0; d_grant = 1'b0; d_enq = 1'b0; d_fence = 1'b0; d_n = 0;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic st(input logic [13:0] a, input logic [3:0] m, input logic [31:0] d);
        st_valid = 1'b1; st_addr = a; st_mask = m; st_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        // Reset with a store and a load presented.
        st(14'h010, 4'b0011, 32'h0000BEEF);
        ld_valid = 1'b1; ld_addr = 14'h100;
        @(negedge clk);
        chk("rst_ready", st_ready, 1'b1);
        chk("rst_en", mem_en, 1'b0);
        chk("rst_grant", ld_grant, 1'b0);
        chk("rst_busy", busy, 1'b0);
        cyc(); rst_n = 1'b1; ld_valid = 1'b0;
        cyc(); st_valid = 1'b0;
        @(negedge clk);
        chk("a_we", mem_we, 4'b0011);
        chk("a_addr", mem_addr, 14'h010);
        chk("a_din", mem_din, 32'h0000BEEF);
        cyc(); @(negedge clk);
        chk("a_empty_en", mem_en, 1'b0);

        // Starvation: loads keep the port for 4 cycles with stores pending.
        cyc(); ld_valid = 1'b1; ld_addr = 14'h100; st(14'h030, 4'hF, 32'h11111111);
        @(negedge clk); chk("sv_c0_grant", ld_grant, 1'b1);
        cyc(); st(14'h034, 4'hF, 32'h22222222);
        @(negedge clk); chk("sv_c1_grant", ld_grant, 1'b1);
        cyc(); st_valid = 1'b0;
        @(negedge clk); chk("sv_full_ready", st_ready, 1'b0); chk("sv_c2_grant", ld_grant, 1'b1);
        cyc(); @(negedge clk); chk("sv_c3_grant", ld_grant, 1'b1);
        cyc(); @(negedge clk); chk("sv_c4_grant", ld_grant, 1'b1);
        cyc(); @(negedge clk);
        chk("sv_forced_grant", ld_grant, 1'b0);
        chk("sv_forced_addr", mem_addr, 14'h030);
        cyc(); ld_valid = 1'b0;
        @(negedge clk); chk("sv_b_din", mem_din, 32'h22222222);
        cyc(); @(negedge clk); chk("sv_empty_en", mem_en, 1'b0);

        // Address hazard: load to a queued address waits one cycle.
        cyc(); ld_valid = 1'b1; ld_addr = 14'h100; st(14'h020, 4'b1100, 32'hCAFE0000);
        @(negedge clk); chk("hz_c0_grant", ld_grant, 1'b1);
        cyc(); st_valid = 1'b0; ld_addr = 14'h020;
        @(negedge clk); chk("hz_grant", ld_grant, 1'b0); chk("hz_we", mem_we, 4'b1100);
        cyc(); @(negedge clk); chk("hz_retry_grant", ld_grant, 1'b1); chk("hz_retry_we", mem_we, 4'b0000);
        cyc(); ld_valid = 1'b0;

        // Fence drain of two queued stores.
        ld_valid = 1'b1; ld_addr = 14'h100; st(14'h040, 4'b0001, 32'h000000AA);
        cyc(); st(14'h044, 4'b0010, 32'h0000BB00);
        cyc(); st_valid = 1'b0; fence = 1'b1;
        @(negedge clk); chk("fn_c0_busy", busy, 1'b0); chk("fn_c0_grant", ld_grant, 1'b1);
        cyc(); fence = 1'b0;
        @(negedge clk);
        chk("fn_busy", busy, 1'b1); chk("fn_ready", st_ready, 1'b0);
        chk("fn_grant", ld_grant, 1'b0); chk("fn_first", mem_addr, 14'h040);
        cyc(); @(negedge clk);
        chk("fn_busy2", busy, 1'b1); chk("fn_second", mem_addr, 14'h044); chk("fn_din2", mem_din, 32'h0000BB00);
        cyc(); @(negedge clk);
        chk("fn_done_busy", busy, 1'b0); chk("fn_done_grant", ld_grant, 1'b1);
        cyc(); ld_valid = 1'b0; fence = 1'b1;
        cyc(); fence = 1'b0;
        @(negedge clk); chk("fn_empty_busy", busy, 1'b0);

        // Reset in the middle of a drain with two entries pending.
        cyc(); ld_valid = 1'b1; ld_addr = 14'h100; st(14'h0E0, 4'hF, 32'hDEAD0001);
        cyc(); st(14'h0F0, 4'hF, 32'hDEAD0002);
        cyc(); st_valid = 1'b0; fence = 1'b1;
        cyc(); fence = 1'b0;
        #1;
        chk("rd_busy_pre", busy, 1'b1);
        chk("rd_en_pre", mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rd_en_async", mem_en, 1'b0);
        chk("rd_busy_async", busy, 1'b0);
        chk("rd_ready_async", st_ready, 1'b1);
        cyc(); rst_n = 1'b1; ld_valid = 1'b0;
        repeat (4) cyc();
        @(negedge clk);
        chk("rd_no_discarded_wr", wr_bad, 0);

        // Zero-mask store: handshake only.
        cyc(); st(14'h050, 4'b0000, 32'h12345678);
        @(negedge clk); chk("m0_ready", st_ready, 1'b1);
        cyc(); st_valid = 1'b0;
        @(negedge clk); chk("m0_en", mem_en, 1'b0); chk("m0_ready2", st_ready, 1'b1);
        cyc(); @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
